// File: rtl/gf_mac_col_if.sv
// Start/done handshake bundle for the GF(2^8) multiply-accumulate column engine.
// The requester drives the operands; the engine returns result, done and busy.
interface gf_mac_col_if #(
    parameter int N_TERMS = 4,
    parameter int COEFF_W = 4,
    parameter int SEL_W   = $clog2(N_TERMS)
);
    logic                       start;
    logic                       abort;
    logic [N_TERMS*8-1:0]       s;
    logic [N_TERMS*COEFF_W-1:0] coeff;
    logic [SEL_W-1:0]           sel;
    logic [7:0]                 result;
    logic                       done;
    logic                       busy;

    modport master (
        output start, abort, s, coeff, sel,
        input  result, done, busy
    );

    modport slave (
        input  start, abort, s, coeff, sel,
        output result, done, busy
    );
endinterface

// File: rtl/gf_mac_col.sv
// Bit-serial GF(2^8) multiply-accumulate of one circulant row against N_TERMS bytes.
// One coefficient bit per cycle, MSB first; fixed latency of N_TERMS*COEFF_W cycles.
module gf_mac_col #(
    parameter int         N_TERMS = 4,
    parameter int         COEFF_W = 4,
    parameter logic [7:0] POLY    = 8'h1B,
    parameter int         SEL_W   = $clog2(N_TERMS)
) (
    input logic          clk,
    input logic          rst,
    gf_mac_col_if.slave  bus
);

    localparam int T_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int B_W = (COEFF_W > 1) ? $clog2(COEFF_W) : 1;
    localparam logic [T_W-1:0] T_LAST = T_W'(N_TERMS - 1);
    localparam logic [B_W-1:0] B_MAX  = B_W'(COEFF_W - 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_e;

    typedef logic [N_TERMS-1:0][7:0]         bytes_t;
    typedef logic [N_TERMS-1:0][COEFF_W-1:0] coeffs_t;

    state_e     state_q, state_d;
    bytes_t     s_q, s_d;
    coeffs_t    c_q, c_d;
    logic [7:0] p_q, p_d;
    logic [7:0] acc_q, acc_d;
    logic [T_W-1:0] t_q, t_d;
    logic [B_W-1:0] b_q, b_d;
    logic [7:0] result_q, result_d;
    logic       done_q, done_d;

    bytes_t           s_in;
    coeffs_t          c_in;
    coeffs_t          c_rot;
    logic [SEL_W-1:0] sel_eff;
    logic [7:0]       s_cur;
    logic             c_bit;
    logic [7:0]       p_next;

    // Out-of-range rotations collapse to the unrotated row.
    assign sel_eff = (int'(bus.sel) >= N_TERMS) ? '0 : bus.sel;
    assign s_in    = bus.s;
    assign c_in    = bus.coeff;

    function automatic logic [T_W-1:0] rot_idx(input int i, input logic [SEL_W-1:0] sel_v);
        return T_W'((i + N_TERMS - int'(sel_v)) % N_TERMS);
    endfunction

    for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_rot
        assign c_rot[gi] = c_in[rot_idx(gi, sel_eff)];
    end

    // Horner step: double the partial product, reduce, then add s_t if the bit is set.
    assign s_cur  = s_q[t_q];
    assign c_bit  = c_q[t_q][b_q];
    assign p_next = {p_q[6:0], 1'b0} ^ (p_q[7] ? POLY : 8'h00) ^ (c_bit ? s_cur : 8'h00);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        s_d      = s_q;
        c_d      = c_q;
        p_d      = p_q;
        acc_d    = acc_q;
        t_d      = t_q;
        b_d      = b_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    s_d     = s_in;
                    c_d     = c_rot;
                    p_d     = 8'h00;
                    acc_d   = 8'h00;
                    t_d     = '0;
                    b_d     = B_MAX;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (b_q != '0) begin
                    p_d = p_next;
                    b_d = b_q - B_W'(1);
                end else if (t_q != T_LAST) begin
                    acc_d = acc_q ^ p_next;
                    p_d   = 8'h00;
                    t_d   = t_q + T_W'(1);
                    b_d   = B_MAX;
                end else begin
                    result_d = acc_q ^ p_next;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            // NOTE: operand storage is reset too; nothing internal is left at X after reset.
            s_q      <= '0;
            c_q      <= '0;
            p_q      <= 8'h00;
            acc_q    <= 8'h00;
            t_q      <= '0;
            b_q      <= '0;
            result_q <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            c_q      <= c_d;
            p_q      <= p_d;
            acc_q    <= acc_d;
            t_q      <= t_d;
            b_q      <= b_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q == MUL);

endmodule

// File: tb/tb_gf_mac_col.sv
// Directed scoreboard bench for gf_mac_col: default 4x4 instance plus a 2-term, 8-bit one.
// Expected results and completion cycles are queued at issue and checked on each done pulse.
module tb_gf_mac_col;

    localparam logic [31:0] S_INV = 32'hbca14d8e;
    localparam logic [15:0] C_INV = 16'h9dbe;
    localparam logic [31:0] S_FWD = 32'h455313db;
    localparam logic [15:0] C_FWD = 16'h1132;
    localparam int          LAT   = 16;
    localparam int          BUDGET = 40;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gf_mac_col_if #(.N_TERMS(4), .COEFF_W(4)) bus ();
    gf_mac_col_if #(.N_TERMS(2), .COEFF_W(8)) bus2 ();

    gf_mac_col #(.N_TERMS(4), .COEFF_W(4), .POLY(8'h1B)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    gf_mac_col #(.N_TERMS(2), .COEFF_W(8), .POLY(8'h1B)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [7:0] res;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t sb2[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;
    int   done_cnt2 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", 32'(bus.result), 32'(e.res));
                check("latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.done === 1'b1) begin
            exp_t e;
            done_cnt2++;
            if (sb2.size() == 0) begin
                check("unexpected_done2", 32'(bus2.done), 32'd0);
            end else begin
                e = sb2.pop_front();
                check("result2", 32'(bus2.result), 32'(e.res));
                check("latency2", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at a falling edge; returns one falling edge later with start released.
    task automatic issue(input logic [31:0] s_v, input logic [15:0] c_v, input logic [1:0] sel_v,
                         input bit expect_done, input logic [7:0] exp_r);
        bus.s     = s_v;
        bus.coeff = c_v;
        bus.sel   = sel_v;
        bus.start = 1'b1;
        if (expect_done) sb.push_back('{res: exp_r, due: cyc + 1 + LAT});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        int n;
        n = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && n < BUDGET) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) check("done_timeout", 32'(bus.done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] inv_exp [4];
        int bc;
        int d0;
        int n;

        inv_exp = '{8'hdb, 8'h13, 8'h53, 8'h45};
        rst = 1'b1;
        bus.start = 1'b0;  bus.abort = 1'b0;  bus.s = '0;  bus.coeff = '0;  bus.sel = '0;
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.s = '0; bus2.coeff = '0; bus2.sel = '0;
        repeat (2) @(negedge clk);
        check("reset_result", 32'(bus.result), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Inverse MixColumns rows selected by rotation
        for (int i = 0; i < 4; i++) begin
            issue(S_INV, C_INV, 2'(i), 1'b1, inv_exp[i]);
            wait_done(bc);
            check("busy_cycles", 32'(bc), 32'(LAT));
            @(negedge clk);
        end

        // Forward row 3, then back-to-back start in the done cycle with row 0
        issue(S_FWD, C_FWD, 2'd3, 1'b1, 8'hbc);
        wait_done(bc);
        check("b2b_busy_in_done", 32'(bus.busy), 32'd0);
        issue(S_FWD, C_FWD, 2'd0, 1'b1, 8'h8e);
        wait_done(bc);
        @(negedge clk);

        // Start pulse while busy is ignored
        d0 = done_cnt;
        issue(S_FWD, C_FWD, 2'd0, 1'b1, 8'h8e);
        repeat (5) @(negedge clk);
        bus.sel = 2'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bc);
        repeat (20) @(negedge clk);
        check("midop_start_dones", 32'(done_cnt - d0), 32'd1);

        // Abort in cycle 7
        d0 = done_cnt;
        issue(S_INV, C_INV, 2'd0, 1'b0, 8'h00);
        repeat (6) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_result_kept", 32'(bus.result), 32'h8e);

        // Abort coincident with the final step
        d0 = done_cnt;
        issue(S_FWD, C_FWD, 2'd3, 1'b0, 8'h00);
        repeat (15) @(negedge clk);
        check("final_step_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("final_abort_done", 32'(bus.done), 32'd0);
        check("final_abort_busy", 32'(bus.busy), 32'd0);
        repeat (5) @(negedge clk);
        check("final_abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("final_abort_result", 32'(bus.result), 32'h8e);

        // Abort together with start in IDLE: start wins
        bus.abort = 1'b1;
        issue(S_FWD, C_FWD, 2'd3, 1'b1, 8'hbc);
        bus.abort = 1'b0;
        wait_done(bc);
        @(negedge clk);

        // Asynchronous reset between edges, mid-operation
        issue(S_INV, C_INV, 2'd1, 1'b0, 8'h00);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_result", 32'(bus.result), 32'd0);
        check("async_rst_done", 32'(bus.done), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(S_FWD, C_FWD, 2'd3, 1'b1, 8'hbc);
        wait_done(bc);
        @(negedge clk);

        // Edge values
        issue(S_INV, 16'h0000, 2'd0, 1'b1, 8'h00);
        wait_done(bc);
        @(negedge clk);
        issue(S_FWD, C_FWD, 2'd0, 1'b1, 8'h8e);
        wait_done(bc);
        @(negedge clk);
        issue(32'hffffffff, 16'h1111, 2'd2, 1'b1, 8'h00);
        wait_done(bc);
        @(negedge clk);

        // Two-term, 8-bit-coefficient instance
        bus2.s     = 16'h0101;
        bus2.coeff = 16'h0302;
        bus2.sel   = 1'b0;
        bus2.start = 1'b1;
        sb2.push_back('{res: 8'h01, due: cyc + 1 + LAT});
        @(negedge clk);
        bus2.start = 1'b0;
        n = 0;
        while (bus2.done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (bus2.done !== 1'b1) check("dut2_timeout", 32'(bus2.done), 32'd1);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("sb2_empty", 32'(sb2.size()), 32'd0);
        check("dut2_dones", 32'(done_cnt2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
